store_queue_ctrl: RTL and testbench
===================================

// Module: store_queue_ctrl
// PURPOSE
//  Sequences stores into data memory for the MEM stage of the 5-stage RV32 pipeline.
//  Each accepted store (sb/sh/sw, from funct3[1:0]) is aligned and given byte enables,
//  then written into a DEPTH-entry FIFO. Entries drain over the single data-memory port,
//  which this block shares with pipeline loads. Loads that hit a pending store stall.
// PARAMETERS
//  DEPTH   4   store-queue entries; power of 2, >=2
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   synchronous active-low reset
//  st_valid   in   1   store request from MEM stage
//  st_ready   out  1   queue can accept (count < DEPTH); combinational
//  st_addr    in   32  byte address
//  st_data    in   32  rs2 value (unaligned; low bits significant)
//  st_size    in   2   funct3[1:0]: 00=sb, 01=sh, 10=sw, 11=illegal
//  st_err     out  1   1-cycle pulse: illegal size or misaligned store rejected
//  ld_valid   in   1   load wants memory port
//  ld_addr    in   32  load byte address
//  ld_stall   out  1   ld_valid & ~ld_done; combinational
//  ld_done    out  1   1-cycle pulse: load granted by memory
//  sq_empty   out  1   queue empty and no store in flight
//  mem_req    out  1   memory request (registered, held until mem_gnt)
//  mem_we     out  1   1=store, 0=load
//  mem_addr   out  32  word-aligned address ({addr[31:2],2'b00})
//  mem_wdata  out  32  lane-aligned write data
//  mem_be     out  4   byte enables (0000 for loads)
//  mem_gnt    in   1   memory accepts request this cycle
// BEHAVIOUR
//  Reset: all of count, rd/wr ptrs, mem_req, mem_we, mem_addr, mem_wdata, mem_be, st_err
//   and ld_done are 0; FSM=IDLE. A reset mid-transaction drops mem_req at the same edge
//   and discards queue contents.
//  Enqueue: st_valid & st_ready & legal -> push at the edge; zero-bubble back-to-back.
//   Legal = size!=11, sh requires addr[0]=0, sw requires addr[1:0]=0.
//   Illegal: no push, st_err=1 on the next cycle.
//   Full queue: st_ready=0 even if a pop happens in the same cycle (no push-on-pop).
//  Alignment (o=addr[1:0]): sb -> be=0001<<o, wdata={4{d[7:0]}};
//   sh -> be=0011<<o, wdata={2{d[15:0]}}; sw -> be=1111, wdata=d.
//  Hazard: hit = ld_valid & any valid entry (or in-flight store) with addr[31:2]==ld_addr[31:2].
//  FSM IDLE -> decision at each edge, priority order:
//   1) count==DEPTH                -> issue head store, go ST_WAIT
//   2) ld_valid & ~hit             -> issue load (we=0, be=0), go LD_WAIT
//   3) count>0                     -> issue head store, go ST_WAIT (hit forces drain)
//   4) else stay IDLE, mem_req=0
//  ST_WAIT: outputs held stable. On mem_gnt: pop head (count-1, rd_ptr wraps mod DEPTH),
//   mem_req=0, go IDLE. A push in that same cycle is allowed; count = count+1-1.
//  LD_WAIT: on mem_gnt, ld_done=1 for 1 cycle, mem_req=0, go IDLE.
//   ld_valid dropping in LD_WAIT is illegal (the pipeline holds it while stalled).
//  Min one-IDLE-cycle turnaround between memory transactions; store latency from push to
//   mem_req >= 1 cycle.
//  sq_empty = (count==0) & (state!=ST_WAIT).
// TESTING
//  1 sw 0x100 d=0xDEADBEEF, mem_gnt tied 1 -> mem_req next cycle, addr 0x100, be=1111,
//    wdata=0xDEADBEEF; sq_empty after gnt.
//  2 sb 0x203 d=0x000000A5 -> be=1000, wdata=0xA5A5A5A5; sh 0x202 d=0x1234 -> be=1100,
//    wdata=0x12341234.
//  3 sh 0x101, sw 0x102, size=11 -> st_err pulses each; no push; count stays 0.
//  4 mem_gnt=0; push 4 stores -> st_ready=0 at count 4; 5th st_valid not accepted;
//    ld_valid held: store has priority (rule 1) and the load waits.
//  5 queue holds sw 0x40; ld 0x42 -> ld_stall until store granted, then load issued,
//    ld_done pulse; ld 0x80 (no hit) with store queued -> load issued first.
//  6 rst_n low during ST_WAIT with 2 entries -> next cycle mem_req=0, count=0, sq_empty=1.

Source files
------------

// File: rtl/store_queue_ctrl_if.sv
// ---------------------------------------------------------------------------
// store_queue_ctrl_if
//   Single-port data-memory bus shared by buffered stores and pipeline loads.
//   master : the requester (store_queue_ctrl) drives req/we/addr/wdata/be
//   slave  : the memory drives gnt
//   Signals:
//     req    request, held until gnt
//     we     1 = store, 0 = load
//     addr   word-aligned byte address
//     wdata  lane-aligned write data
//     be     byte enables (4'b0000 for loads)
//     gnt    memory accepts the request in this cycle
// ---------------------------------------------------------------------------
interface store_queue_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;

    modport master (output req, output we, output addr, output wdata, output be, input gnt);
    modport slave  (input req, input we, input addr, input wdata, input be, output gnt);
endinterface

// File: rtl/store_queue_ctrl.sv
// ---------------------------------------------------------------------------
// store_queue_ctrl
//   MEM-stage store buffer for a 5-stage RV32 pipeline. Stores (sb/sh/sw) are
//   checked for legality, lane-aligned with byte enables and pushed into a
//   DEPTH-entry FIFO. The FIFO drains over the single memory port, which is
//   shared with pipeline loads; a load that hits a buffered store stalls until
//   the buffer has drained past it.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     st_valid_i     store request            st_ready_o  queue not full
//     st_addr_i      store byte address       st_data_i   rs2 value
//     st_size_i      funct3[1:0]              st_err_o    illegal/misaligned pulse
//     ld_valid_i     load wants memory        ld_addr_i   load byte address
//     ld_stall_o     load still waiting       ld_done_o   load granted pulse
//     sq_empty_o     no buffered or in-flight store
//     mem            memory bus (master side)
// ---------------------------------------------------------------------------
module store_queue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid_i,
    output logic                       st_ready_o,
    input  logic [31:0]                st_addr_i,
    input  logic [31:0]                st_data_i,
    input  logic [1:0]                 st_size_i,
    output logic                       st_err_o,
    input  logic                       ld_valid_i,
    input  logic [31:0]                ld_addr_i,
    output logic                       ld_stall_o,
    output logic                       ld_done_o,
    output logic                       sq_empty_o,
    store_queue_ctrl_if.master         mem
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ST_WAIT = 2'b01,
        LD_WAIT = 2'b10
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [29:0]     q_addr_q  [DEPTH];
    logic [31:0]     q_wdata_q [DEPTH];
    logic [3:0]      q_be_q    [DEPTH];

    logic            st_err_q;
    logic            ld_done_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [31:0]     mem_addr_q;
    logic [31:0]     mem_wdata_q;
    logic [3:0]      mem_be_q;

    logic            legal_s;
    logic            push_s;
    logic            pop_s;
    logic            hit_s;
    logic            load_ok_s;
    logic            issue_st_s;
    logic [PW-1:0]   rel_s;
    logic [3:0]      enq_be_s;
    logic [31:0]     enq_wdata_s;
    logic            unused_ld_lsb_s;

    // Only the word address of a load matters for hazard detection.
    assign unused_ld_lsb_s = ^ld_addr_i[1:0];

    // No push-on-pop: readiness looks only at the registered occupancy.
    assign st_ready_o = (count_q != FULL);
    assign push_s     = st_valid_i & st_ready_o & legal_s;
    assign pop_s      = (state_q == ST_WAIT) & mem.gnt;
    assign count_d    = count_q + CW'(push_s) - CW'(pop_s);
    assign rd_ptr_d   = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    assign wr_ptr_d   = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;

    assign st_err_o   = st_err_q;
    assign ld_done_o  = ld_done_q;
    assign ld_stall_o = ld_valid_i & ~ld_done_q;
    assign sq_empty_o = (count_q == {CW{1'b0}}) & (state_q != ST_WAIT);

    assign mem.req    = mem_req_q;
    assign mem.we     = mem_we_q;
    assign mem.addr   = mem_addr_q;
    assign mem.wdata  = mem_wdata_q;
    assign mem.be     = mem_be_q;

    // Store legality and lane alignment of the incoming store.
    always_comb begin
        legal_s     = 1'b0;
        enq_be_s    = 4'b0000;
        enq_wdata_s = 32'h0000_0000;
        case (st_size_i)
            2'b00: begin
                legal_s     = 1'b1;
                enq_be_s    = 4'b0001 << st_addr_i[1:0];
                enq_wdata_s = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                legal_s     = ~st_addr_i[0];
                enq_be_s    = 4'b0011 << st_addr_i[1:0];
                enq_wdata_s = {2{st_data_i[15:0]}};
            end
            2'b10: begin
                legal_s     = (st_addr_i[1:0] == 2'b00);
                enq_be_s    = 4'b1111;
                enq_wdata_s = st_data_i;
            end
            default: begin
                legal_s     = 1'b0;
                enq_be_s    = 4'b0000;
                enq_wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Load hazard: word-address match against every occupied entry. The store
    // being issued stays at the head until granted, so it is covered as well.
    always_comb begin
        hit_s = 1'b0;
        rel_s = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rel_s = PW'(i) - rd_ptr_q;
            hit_s = hit_s | (({1'b0, rel_s} < count_q) && (q_addr_q[i] == ld_addr_i[31:2]));
        end
        hit_s = hit_s & ld_valid_i;
    end

    // IDLE arbitration: a full queue drains first, then a non-hitting load,
    // then any buffered store (a hitting load forces the drain).
    assign load_ok_s  = ld_valid_i & ~hit_s;
    assign issue_st_s = (count_q == FULL) | (~load_ok_s & (count_q != {CW{1'b0}}));

    // Queue storage; unoccupied entries are never read, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_addr_q[wr_ptr_q]  <= st_addr_i[31:2];
            q_wdata_q[wr_ptr_q] <= enq_wdata_s;
            q_be_q[wr_ptr_q]    <= enq_be_s;
        end
    end

    // Queue occupancy, pointers and the illegal-store pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= {CW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            st_err_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            st_err_q <= st_valid_i & st_ready_o & ~legal_s;
        end
    end

    // Memory-port FSM with registered bus outputs; every grant returns to
    // IDLE, giving one idle cycle between transactions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            ld_done_q   <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue_st_s) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {q_addr_q[rd_ptr_q], 2'b00};
                        mem_wdata_q <= q_wdata_q[rd_ptr_q];
                        mem_be_q    <= q_be_q[rd_ptr_q];
                        state_q     <= ST_WAIT;
                    end else if (load_ok_s) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= {ld_addr_i[31:2], 2'b00};
                        mem_wdata_q <= 32'h0000_0000;
                        mem_be_q    <= 4'b0000;
                        state_q     <= LD_WAIT;
                    end else begin
                        mem_req_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                ST_WAIT: begin
                    if (mem.gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                LD_WAIT: begin
                    if (mem.gnt) begin
                        mem_req_q <= 1'b0;
                        ld_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_queue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_store_queue_ctrl
//   Directed bench for store_queue_ctrl. Stimulus pushes the hand-computed
//   memory transactions into exp_q in the order they must appear on the bus;
//   a monitor pops and compares on every accepted request (req & gnt).
// ---------------------------------------------------------------------------
module tb_store_queue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_err;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        ld_done;
    logic        sq_empty;

    store_queue_ctrl_if mem_if ();

    store_queue_ctrl #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid_i (st_valid),
        .st_ready_o (st_ready),
        .st_addr_i  (st_addr),
        .st_data_i  (st_data),
        .st_size_i  (st_size),
        .st_err_o   (st_err),
        .ld_valid_i (ld_valid),
        .ld_addr_i  (ld_addr),
        .ld_stall_o (ld_stall),
        .ld_done_o  (ld_done),
        .sq_empty_o (sq_empty),
        .mem        (mem_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t exp_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   err_pulses  = 0;
    int   done_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.be = be;
        return t;
    endfunction

    // Scoreboard monitor: one bus transaction per accepted request.
    always @(negedge clk) begin
        txn_t e;
        if (rst_n && mem_if.req && mem_if.gnt) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected: got we=%0b addr=0x%08h be=%b, expected no transaction",
                         mem_if.we, mem_if.addr, mem_if.be);
            end else begin
                e = exp_q.pop_front();
                check("mem_we",    {31'd0, mem_if.we}, {31'd0, e.we});
                check("mem_addr",  mem_if.addr,        e.addr);
                check("mem_wdata", mem_if.wdata,       e.wdata);
                check("mem_be",    {28'd0, mem_if.be}, {28'd0, e.be});
            end
        end
    end

    always @(negedge clk) begin
        if (st_err)  err_pulses++;
        if (ld_done) done_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz;
        @(negedge clk);
        check("st_ready_on_push", {31'd0, st_ready}, 32'd1);
        step();
        st_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (n < budget && !(exp_q.size() == 0 && sq_empty && !mem_if.req)) begin
            @(negedge clk);
            n++;
        end
        check("drain_complete", {31'd0, (exp_q.size() == 0 && sq_empty && !mem_if.req)}, 32'd1);
    endtask

    task automatic wait_ld_done(input int budget, input logic nv, input logic [31:0] na);
        int n;
        n = 0;
        @(negedge clk);
        while (!ld_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("ld_done_seen",     {31'd0, ld_done},  32'd1);
        check("ld_stall_on_done", {31'd0, ld_stall}, 32'd0);
        ld_valid = nv;
        ld_addr  = na;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; st_valid = 1'b0; st_addr = 32'd0; st_data = 32'd0; st_size = 2'b00;
        ld_valid = 1'b0; ld_addr = 32'd0; mem_if.gnt = 1'b0;

        // Reset state
        step(); step();
        check("rst_mem_req",   {31'd0, mem_if.req},  32'd0);
        check("rst_mem_we",    {31'd0, mem_if.we},   32'd0);
        check("rst_mem_addr",  mem_if.addr,          32'd0);
        check("rst_mem_wdata", mem_if.wdata,         32'd0);
        check("rst_mem_be",    {28'd0, mem_if.be},   32'd0);
        check("rst_st_err",    {31'd0, st_err},      32'd0);
        check("rst_ld_done",   {31'd0, ld_done},     32'd0);
        check("rst_sq_empty",  {31'd0, sq_empty},    32'd1);
        check("rst_st_ready",  {31'd0, st_ready},    32'd1);
        rst_n = 1'b1;

        // 1: sw 0x100, gnt tied high
        step();
        mem_if.gnt = 1'b1;
        exp_q.push_back(mk(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111));
        push_store(32'h0000_0100, 32'hDEAD_BEEF, 2'b10);
        @(negedge clk);
        check("t1_req_not_same_cycle", {31'd0, mem_if.req}, 32'd0);
        @(negedge clk);
        check("t1_req_next_cycle",     {31'd0, mem_if.req}, 32'd1);
        wait_drain(20);

        // 2: sb / sh lane alignment, back to back
        step();
        exp_q.push_back(mk(1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000));
        exp_q.push_back(mk(1'b1, 32'h0000_0200, 32'h1234_1234, 4'b1100));
        push_store(32'h0000_0203, 32'h0000_00A5, 2'b00);
        push_store(32'h0000_0202, 32'h0000_1234, 2'b01);
        wait_drain(30);

        // 3: illegal stores
        step();
        push_store(32'h0000_0101, 32'h1111_1111, 2'b01);
        push_store(32'h0000_0102, 32'h2222_2222, 2'b10);
        push_store(32'h0000_0100, 32'h3333_3333, 2'b11);
        step(); step();
        check("t3_err_pulses", err_pulses,             32'd3);
        check("t3_st_err_low", {31'd0, st_err},        32'd0);
        check("t3_sq_empty",   {31'd0, sq_empty},      32'd1);
        check("t3_no_req",     {31'd0, mem_if.req},    32'd0);

        // 4: fill with gnt=0, load held, full-queue priority
        step();
        mem_if.gnt = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h0000_0300;
        exp_q.push_back(mk(1'b0, 32'h0000_0300, 32'h0000_0000, 4'b0000));
        exp_q.push_back(mk(1'b1, 32'h0000_0010, 32'h1111_1111, 4'b1111));
        exp_q.push_back(mk(1'b0, 32'h0000_0304, 32'h0000_0000, 4'b0000));
        exp_q.push_back(mk(1'b1, 32'h0000_0014, 32'h2222_2222, 4'b1111));
        exp_q.push_back(mk(1'b1, 32'h0000_0018, 32'h3333_3333, 4'b1111));
        exp_q.push_back(mk(1'b1, 32'h0000_001C, 32'h4444_4444, 4'b1111));
        push_store(32'h0000_0010, 32'h1111_1111, 2'b10);
        push_store(32'h0000_0014, 32'h2222_2222, 2'b10);
        push_store(32'h0000_0018, 32'h3333_3333, 2'b10);
        push_store(32'h0000_001C, 32'h4444_4444, 2'b10);
        st_valid = 1'b1; st_addr = 32'h0000_0020; st_data = 32'h5555_5555; st_size = 2'b10;
        @(negedge clk);
        check("t4_full_not_ready", {31'd0, st_ready}, 32'd0);
        check("t4_ld_stall",       {31'd0, ld_stall}, 32'd1);
        @(negedge clk);
        check("t4_full_not_ready2", {31'd0, st_ready}, 32'd0);
        step();
        st_valid = 1'b0;
        mem_if.gnt = 1'b1;
        wait_ld_done(20, 1'b1, 32'h0000_0304);
        @(negedge clk);
        check("t4_full_store_first", {31'd0, mem_if.we}, 32'd1);
        check("t4_load_waits",       {31'd0, ld_stall},  32'd1);
        check("t4_no_push_on_pop",   {31'd0, st_ready},  32'd0);
        wait_ld_done(20, 1'b0, 32'h0000_0000);
        wait_drain(40);

        // 5a: load hitting a buffered store waits for the drain
        step();
        mem_if.gnt = 1'b0;
        exp_q.push_back(mk(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111));
        exp_q.push_back(mk(1'b0, 32'h0000_0040, 32'h0000_0000, 4'b0000));
        push_store(32'h0000_0040, 32'hCAFE_F00D, 2'b10);
        ld_valid = 1'b1; ld_addr = 32'h0000_0042;
        @(negedge clk);
        check("t5_hit_stall",       {31'd0, ld_stall},   32'd1);
        @(negedge clk);
        check("t5_hit_drains_store", {31'd0, mem_if.we}, 32'd1);
        check("t5_hit_req",          {31'd0, mem_if.req}, 32'd1);
        check("t5_hit_stall2",       {31'd0, ld_stall},  32'd1);
        step();
        mem_if.gnt = 1'b1;
        wait_ld_done(20, 1'b0, 32'h0000_0000);
        wait_drain(20);

        // 5b: non-hitting load overtakes a queued store
        step();
        exp_q.push_back(mk(1'b0, 32'h0000_0080, 32'h0000_0000, 4'b0000));
        exp_q.push_back(mk(1'b1, 32'h0000_0050, 32'h0000_0055, 4'b1111));
        push_store(32'h0000_0050, 32'h0000_0055, 2'b10);
        ld_valid = 1'b1; ld_addr = 32'h0000_0080;
        wait_ld_done(20, 1'b0, 32'h0000_0000);
        wait_drain(20);

        // 6: reset during ST_WAIT with two entries
        step();
        mem_if.gnt = 1'b0;
        push_store(32'h0000_0060, 32'h6666_6666, 2'b10);
        push_store(32'h0000_0064, 32'h7777_7777, 2'b10);
        @(negedge clk);
        check("t6_req_before_rst", {31'd0, mem_if.req}, 32'd1);
        check("t6_not_empty",      {31'd0, sq_empty},   32'd0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_req_dropped", {31'd0, mem_if.req}, 32'd0);
        check("t6_sq_empty",    {31'd0, sq_empty},   32'd1);
        check("t6_st_ready",    {31'd0, st_ready},   32'd1);
        mem_if.gnt = 1'b1;
        step(); step(); step(); step();
        check("t6_queue_discarded", {31'd0, mem_if.req}, 32'd0);
        check("t6_still_empty",     {31'd0, sq_empty},   32'd1);

        // Totals
        check("final_exp_q_empty", exp_q.size(), 32'd0);
        check("final_ld_done",     done_pulses,  32'd4);
        check("final_st_err",      err_pulses,   32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
